// File: rtl/ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl
//   Iterative unsigned multiply / divide unit for the EX stage. One operation
//   takes 32 iterations (one per cycle). The unit stalls the front of the
//   pipeline while it works and pulses DoneE for one cycle when the result is
//   valid.
//
//   State table:
//     state | meaning
//     IDLE  | waiting for StartE; operands latched on accept
//     BUSY  | one shift-add / restoring-divide iteration per cycle
//     DONE  | result presented on MDResultE, DoneE high for this cycle
//     (3)   | illegal encoding, recovers to IDLE
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-low
//   StartE     mul/div instruction present in EX (held while stalled)
//   MDOpE      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   SrcAE      multiplicand / dividend
//   SrcBE      multiplier / divisor
//   AbortE     flush of EX; cancels any operation in flight
//   StallMD    stall request to the hazard unit
//   DoneE      one-cycle completion pulse
//   MDResultE  result, held until the next completion
//   BusyE      high while iterating
// ---------------------------------------------------------------------------
module ex_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       MDOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             AbortE,
  output logic             StallMD,
  output logic             DoneE,
  output logic [WIDTH-1:0] MDResultE,
  output logic             BusyE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next;

  logic [CNTW-1:0]    r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_mcand;
  // Low half starts as the multiplier and is shifted out LSB first while the
  // partial product grows into the high half.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_div;
  // Starts as the dividend; its MSB feeds the remainder each step and the new
  // quotient bit enters at the LSB.
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_result;

  logic               w_start;
  logic               w_done;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH+1:0]   w_shift;
  logic               w_ge;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_final;

  assign w_start = (r_state == S_IDLE) && StartE && !AbortE;
  assign w_done  = (r_state == S_DONE) && !AbortE;

  // Multiply step
  assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  // Restoring divide step. The remainder is always below the divisor, so the
  // shifted value fits in WIDTH+1 bits whenever the subtraction is taken.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = w_shift >= {2'b00, r_div};
  assign w_sub   = w_shift[WIDTH:0] - {1'b0, r_div};

  always_comb begin
    w_final = r_rem[WIDTH-1:0];
    case (r_op)
      OP_MUL:   w_final = r_acc[WIDTH-1:0];
      OP_MULHU: w_final = r_acc[2*WIDTH-1:WIDTH];
      OP_DIVU:  w_final = r_q;
      default:  w_final = r_rem[WIDTH-1:0];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (StartE && !AbortE) w_next = S_BUSY;
        else                   w_next = S_IDLE;
      end
      S_BUSY: begin
        if (AbortE)                 w_next = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next = S_DONE;
        else                        w_next = S_BUSY;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs. In DONE the freshly computed value is forwarded so it is valid in
  // the same cycle as the DoneE pulse; the register keeps it afterwards.
  always_comb begin
    StallMD   = w_start || (r_state == S_BUSY);
    BusyE     = (r_state == S_BUSY);
    DoneE     = w_done;
    MDResultE = w_done ? w_final : r_result;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      if (w_start) begin
        r_cnt   <= '0;
        r_op    <= MDOpE;
        r_mcand <= SrcAE;
        r_acc   <= {{WIDTH{1'b0}}, SrcBE};
        r_div   <= SrcBE;
        r_q     <= SrcAE;
        r_rem   <= '0;
      end else if ((r_state == S_BUSY) && !AbortE) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= {w_madd, r_acc[WIDTH-1:1]};
        r_rem <= w_ge ? w_sub : w_shift[WIDTH:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end

      if (w_done) begin
        r_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        StartE;
  logic [1:0]  MDOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        AbortE;
  logic        StallMD;
  logic        DoneE;
  logic [31:0] MDResultE;
  logic        BusyE;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  ex_muldiv_ctrl #(.WIDTH(32), .CNTW(5)) dut (
    .clk       (clk),
    .reset     (reset_n),
    .StartE    (StartE),
    .MDOpE     (MDOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .AbortE    (AbortE),
    .StallMD   (StallMD),
    .DoneE     (DoneE),
    .MDResultE (MDResultE),
    .BusyE     (BusyE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every DoneE pops the oldest expected result.
  always @(negedge clk) begin
    if (DoneE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(MDResultE), 64'hDEAD_0000_0000_0000);
      end else begin
        chk("result", 64'(MDResultE), 64'(exp_q.pop_front()));
      end
    end
  end

  // Issues one operation with StartE held until DoneE; leaves StartE high so a
  // following call issues back-to-back.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int t_done);
    int  stall_n;
    int  busy_n;
    int  done_k;
    bit  seen;
    exp_q.push_back(model(op, a, b));
    last_res = model(op, a, b);
    @(posedge clk); #1;
    MDOpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1; AbortE = 1'b0;
    stall_n = 0; busy_n = 0; done_k = -1; seen = 1'b0; t_done = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (StallMD) stall_n++;
      if (BusyE)   busy_n++;
      if (DoneE) begin
        seen = 1'b1; done_k = k; t_done = cyc;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        SrcAE = $urandom; SrcBE = $urandom; MDOpE = 2'($urandom_range(3, 0));
      end
    end
    chk("done_latency", 64'(done_k), 64'd33);
    chk("stall_cycles", 64'(stall_n), 64'd33);
    chk("busy_cycles",  64'(busy_n),  64'd32);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    StartE = 1'b0; AbortE = 1'b0;
  endtask

  int t1, t2, dones;
  logic [31:0] ra, rb;
  logic [1:0]  rop;

  initial begin
    reset_n = 1'b0; StartE = 1'b0; AbortE = 1'b0; MDOpE = 2'd0; SrcAE = '0; SrcBE = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 64'(MDResultE), 64'd0);
    chk("rst_done",   64'(DoneE),     64'd0);
    chk("rst_busy",   64'(BusyE),     64'd0);
    chk("rst_stall",  64'(StallMD),   64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Abort has priority over StartE in IDLE
    @(posedge clk); #1;
    StartE = 1'b1; AbortE = 1'b1;
    @(negedge clk);
    chk("idle_abort_stall", 64'(StallMD), 64'd0);
    go_idle();
    @(negedge clk);
    chk("idle_abort_busy", 64'(BusyE), 64'd0);

    // MUL with StartE held
    run_op(2'd0, 32'h0001_2345, 32'h0000_0100, 1'b0, t1);
    chk("mul_const", 64'(last_res), 64'h0123_4500);
    go_idle();

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t1);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t1);
    go_idle();

    run_op(2'd2, 32'd100, 32'd7, 1'b0, t1);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, t1);
    run_op(2'd2, 32'd5,   32'd0, 1'b0, t1);
    run_op(2'd3, 32'd5,   32'd0, 1'b0, t1);
    go_idle();

    // Abort of a DIVU in cycle 10
    @(posedge clk); #1;
    MDOpE = 2'd2; SrcAE = 32'd100; SrcBE = 32'd7; StartE = 1'b1;
    repeat (10) @(posedge clk); #1;
    AbortE = 1'b1;
    @(posedge clk); #1;
    AbortE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    chk("abort_stall",  64'(StallMD),   64'd0);
    chk("abort_busy",   64'(BusyE),     64'd0);
    chk("abort_done",   64'(DoneE),     64'd0);
    chk("abort_result", 64'(MDResultE), 64'(last_res));
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneE) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);

    // Reset in cycle 20 of a MUL
    @(posedge clk); #1;
    MDOpE = 2'd0; SrcAE = 32'd1234; SrcBE = 32'd5678; StartE = 1'b1;
    repeat (20) @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; StartE = 1'b0;
    @(negedge clk);
    chk("midrst_busy",   64'(BusyE),     64'd0);
    chk("midrst_done",   64'(DoneE),     64'd0);
    chk("midrst_result", 64'(MDResultE), 64'd0);
    chk("midrst_stall",  64'(StallMD),   64'd0);
    run_op(2'd0, 32'd1234, 32'd5678, 1'b0, t1);
    go_idle();

    // Back-to-back MUL then DIVU with operand noise during BUSY
    run_op(2'd0, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, t1);
    run_op(2'd2, 32'hFEDC_BA98, 32'h0000_1234, 1'b1, t2);
    chk("b2b_gap", 64'(t2 - t1), 64'd34);
    go_idle();

    // A few random operations
    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(31, 0));
      rop = 2'(i);
      run_op(rop, ra, rb, 1'b1, t1);
    end
    go_idle();

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
